// File: rtl/apb_master_ctrl.sv
// Bridges a single-outstanding CPU bus request onto an APB3 bus with NUM_SLV
// address-decoded slaves; returns read data and an error flag with a one-cycle done pulse.
module apb_master_ctrl #(
  parameter int          NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          SLV_SHIFT = 12,
  parameter int          TIMEOUT   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    we,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    done,
  output logic                    err,
  output logic [31:0]             PADDR,
  output logic                    PWRITE,
  output logic [31:0]             PWDATA,
  output logic                    PENABLE,
  output logic [NUM_SLV-1:0]      PSEL,
  input  logic [32*NUM_SLV-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]      PREADY
);

  localparam int IDXW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNTW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t              state_reg, state_next;
  logic [NUM_SLV-1:0]  psel_reg, psel_next;
  logic                penable_reg, penable_next;
  logic [31:0]         paddr_reg, paddr_next;
  logic                pwrite_reg, pwrite_next;
  logic [31:0]         pwdata_reg, pwdata_next;
  logic [31:0]         rdata_reg, rdata_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;
  logic [IDXW-1:0]     idx_reg, idx_next;
  logic [CNTW-1:0]     cnt_reg, cnt_next;

  logic [31:0] offset;
  logic [31:0] slot;
  logic        hit;
  logic [31:0] prdata_arr [NUM_SLV];
  logic [31:0] sel_rdata;
  logic        sel_ready;

  generate
    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slice
      assign prdata_arr[gi] = PRDATA[32*gi +: 32];
    end
  endgenerate

  // Subtraction wraps for addresses below BASE_ADDR, so the >= test is what rejects them.
  assign offset    = addr - BASE_ADDR;
  assign slot      = offset >> SLV_SHIFT;
  assign hit       = (addr >= BASE_ADDR) && (slot < 32'(NUM_SLV));
  assign sel_rdata = prdata_arr[idx_reg];
  assign sel_ready = PREADY[idx_reg];

  always_comb begin
    state_next   = state_reg;
    psel_next    = psel_reg;
    penable_next = penable_reg;
    paddr_next   = paddr_reg;
    pwrite_next  = pwrite_reg;
    pwdata_next  = pwdata_reg;
    rdata_next   = rdata_reg;
    err_next     = err_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req) begin
          paddr_next  = addr;
          pwrite_next = we;
          pwdata_next = wdata;
          if (hit) begin
            idx_next   = slot[IDXW-1:0];
            psel_next  = NUM_SLV'(1) << slot[IDXW-1:0];
            state_next = SETUP;
          end else begin
            rdata_next = '0;
            err_next   = 1'b1;
            done_next  = 1'b1;
            state_next = DONE;
          end
        end
      end
      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
      end
      ACCESS: begin
        if (sel_ready || (cnt_reg == CNTW'(TIMEOUT - 1))) begin
          rdata_next   = sel_ready ? sel_rdata : '0;
          err_next     = ~sel_ready;
          psel_next    = '0;
          penable_next = 1'b0;
          cnt_next     = '0;
          done_next    = 1'b1;
          state_next   = DONE;
        end else begin
          cnt_next = cnt_reg + CNTW'(1);
        end
      end
      DONE: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      psel_reg    <= '0;
      penable_reg <= 1'b0;
      paddr_reg   <= '0;
      pwrite_reg  <= 1'b0;
      pwdata_reg  <= '0;
      rdata_reg   <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      idx_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      psel_reg    <= psel_next;
      penable_reg <= penable_next;
      paddr_reg   <= paddr_next;
      pwrite_reg  <= pwrite_next;
      pwdata_reg  <= pwdata_next;
      rdata_reg   <= rdata_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign PSEL    = psel_reg;
  assign PENABLE = penable_reg;
  assign PADDR   = paddr_reg;
  assign PWRITE  = pwrite_reg;
  assign PWDATA  = pwdata_reg;
  assign rdata   = rdata_reg;
  assign done    = done_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Randomised bench for apb_master_ctrl: behavioural slaves plus a transaction-level
// model predicting decode, latency, read data and error for every transfer.
module tb_apb_master_ctrl;

  localparam int          NUM_SLV   = 4;
  localparam logic [31:0] BASE      = 32'h1000_0000;
  localparam int          SLV_SHIFT = 12;
  localparam int          TIMEOUT   = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req;
  logic                  we;
  logic [31:0]           addr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  done;
  logic                  err;
  logic [31:0]           PADDR;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic                  PENABLE;
  logic [NUM_SLV-1:0]    PSEL;
  logic [32*NUM_SLV-1:0] PRDATA;
  logic [NUM_SLV-1:0]    PREADY;

  int checks = 0;
  int errors = 0;

  apb_master_ctrl #(
    .NUM_SLV(NUM_SLV), .BASE_ADDR(BASE), .SLV_SHIFT(SLV_SHIFT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .err(err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
    .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One CPU transfer. waits = PREADY wait states of the target, stuck = target never ready,
  // hold = keep req high after done, extra = idle cycles before the request can be taken.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] sdata, input int waits, input bit stuck,
                      input bit hold, input int extra);
    logic [31:0] off;
    bit hit, got;
    int idx, exp_lat, cyc, acc, sel_cyc, en_cyc;
    logic [31:0] exp_rd;
    logic exp_err;
    logic [NUM_SLV-1:0] exp_sel;

    off     = a - BASE;
    hit     = (a >= BASE) && ((off >> SLV_SHIFT) < NUM_SLV);
    idx     = hit ? int'(off >> SLV_SHIFT) : 0;
    exp_sel = hit ? (NUM_SLV'(1) << idx) : '0;
    if (!hit) begin
      exp_lat = 1; exp_rd = '0; exp_err = 1'b1;
    end else if (stuck) begin
      exp_lat = 2 + TIMEOUT; exp_rd = '0; exp_err = 1'b1;
    end else begin
      exp_lat = 3 + waits; exp_rd = sdata; exp_err = 1'b0;
    end
    exp_lat += extra;

    req = 1'b1; we = wr; addr = a; wdata = wd;
    cyc = 0; acc = 0; got = 0; sel_cyc = 0; en_cyc = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc > extra) begin
        we = 1'($urandom); addr = $urandom; wdata = $urandom;
      end
      if (PSEL != '0) begin
        sel_cyc++;
        check("psel_onehot", 32'(PSEL), 32'(exp_sel));
        check("paddr", PADDR, a);
        check("pwdata", PWDATA, wd);
        check("pwrite", 32'(PWRITE), 32'(wr));
      end
      if (PENABLE) en_cyc++;
      if (done) begin
        got = 1;
        check("latency", 32'(cyc), 32'(exp_lat));
        check("rdata", rdata, exp_rd);
        check("err", 32'(err), 32'(exp_err));
        check("psel_clr", 32'(PSEL), 32'h0);
        check("penable_clr", 32'(PENABLE), 32'h0);
      end
      for (int i = 0; i < NUM_SLV; i++) begin
        PREADY[i] = 1'($urandom);
        PRDATA[32*i +: 32] = $urandom;
      end
      if (hit) begin
        PREADY[idx] = 1'b0;
        if (PENABLE && PSEL[idx]) begin
          if (!stuck && acc == waits) begin
            PREADY[idx] = 1'b1;
            PRDATA[32*idx +: 32] = sdata;
          end
          acc++;
        end
      end
    end
    check("done_seen", 32'(got), 32'h1);
    check("psel_cycles", 32'(sel_cyc), hit ? 32'(exp_lat - extra - 1) : 32'h0);
    check("penable_cycles", 32'(en_cyc), hit ? 32'(exp_lat - extra - 2) : 32'h0);
    $display("xfer we=%0d addr=%h wdata=%h waits=%0d stuck=%0d -> rdata=%h err=%0d lat=%0d",
             wr, a, wd, waits, stuck, rdata, err, cyc);
    req = hold;
    if (!hold) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found, seen, prev_hold, hold, stuck;
    int kind, slv, waits;
    logic [31:0] a;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    PRDATA = '0; PREADY = '0;
    repeat (3) @(negedge clk);
    check("rst_psel", 32'(PSEL), 32'h0);
    check("rst_penable", 32'(PENABLE), 32'h0);
    check("rst_pwrite", 32'(PWRITE), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    xfer(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, $urandom, 0, 1'b0, 1'b0, 0);
    xfer(1'b0, 32'h1000_2010, $urandom, 32'h1234_5678, 3, 1'b0, 1'b0, 0);
    xfer(1'b0, 32'h1000_4000, $urandom, $urandom, 0, 1'b0, 1'b0, 0);
    xfer(1'b1, 32'h0FFF_FFFC, $urandom, $urandom, 0, 1'b0, 1'b0, 0);
    xfer(1'b0, 32'h1000_1000, $urandom, $urandom, 0, 1'b1, 1'b0, 0);
    xfer(1'b1, 32'h1000_3008, $urandom, $urandom, 1, 1'b0, 1'b1, 0);
    xfer(1'b0, 32'h1000_1010, $urandom, 32'hCAFE_F00D, 2, 1'b0, 1'b0, 1);

    // Reset while the bus sits in ACCESS against a never-ready slave.
    req = 1'b1; we = 1'b0; addr = BASE + 32'h1000; wdata = $urandom; found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      PREADY = '0;
      if (PENABLE) found = 1;
    end
    check("rst_reach_access", 32'(found), 32'h1);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    check("midrst_psel", 32'(PSEL), 32'h0);
    check("midrst_penable", 32'(PENABLE), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_paddr", PADDR, 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    rst = 1'b0; seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("midrst_no_done", 32'(seen), 32'h0);
    $display("reset during ACCESS: found=%0d done_after=%0d", found, seen);
    xfer(1'b0, 32'h1000_2000, $urandom, $urandom, 0, 1'b0, 1'b0, 0);

    prev_hold = 0;
    for (int t = 0; t < 40; t++) begin
      kind  = $urandom_range(0, 9);
      slv   = $urandom_range(0, NUM_SLV - 1);
      waits = $urandom_range(0, 4);
      stuck = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 3) == 0);
      if (kind == 0)
        a = $urandom % BASE;
      else if (kind == 1)
        a = BASE + (32'(NUM_SLV) << SLV_SHIFT) + ($urandom % 32'h0010_0000);
      else
        a = BASE + (32'(slv) << SLV_SHIFT) + (($urandom % 32'd4096) & 32'hFFFF_FFFC);
      xfer(1'($urandom), a, $urandom, $urandom, waits, stuck, hold, prev_hold ? 1 : 0);
      prev_hold = hold;
    end
    if (prev_hold) begin
      req = 1'b0;
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
